// File: rtl/cla_seq_adder.sv
// Purpose: WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice, LSB slice first.
// Latency: result and done arrive WIDTH/4 edges after start is accepted; done lasts one cycle.
// Backpressure: ready is low while slices are being processed; start is ignored then and never queued.

// 4-bit carry-lookahead slice: all carries come from generate/propagate terms, with no ripple between bits.
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
        s     = p ^ c[3:0];
        c_out = c[4];
    end

endmodule

// Sequential adder top: one slice per clock, with the carry registered between slices.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    // WIDTH must be a multiple of 4 and at least 8, so the counter is always at least 1 bit wide.
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_slice;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CW+1:0]    slice_lsb;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    // Select the slice for this cycle. The counter is only meaningful in RUN.
    always_comb begin
        slice_lsb = {cnt, 2'b00};
        slice_a   = op_a[slice_lsb +: 4];
        slice_b   = op_b[slice_lsb +: 4];
    end

    cla_4b u_cla (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .s     (slice_sum),
        .c_out (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. DONE also accepts, so back-to-back operations leave no bubble.
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_slice = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last_slice) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then write one result slice per RUN cycle.
    // Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum[slice_lsb +: 4] <= slice_sum;
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            if (last_slice) begin
                c_out <= slice_cout;
                ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_sum[3] != op_a[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder (WIDTH=16): scoreboard of expected results, pushed when an operation is issued
// and popped when done is seen. Outputs are sampled on the falling edge or just after an async reset.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a 17-bit sum gives the carry. Signed overflow is judged from operand and result signs.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [16:0] full;
        exp_t        e;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   full = {1'b0, x} + {1'b0, y};
        e.sum = full[15:0];
        e.c   = full[16];
        if (s) e.v = (x[15] != y[15]) && (e.sum[15] != x[15]);
        else   e.v = (x[15] == y[15]) && (e.sum[15] != x[15]);
        return e;
    endfunction

    // Presents one operation from idle and releases start just after the accepting edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        sb.push_back(model(x, y, s));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until done. Returns -1 if done never arrives within the budget.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", k, ready); end
            vectors++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", k, done); end
            vectors++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum[%0d]: got %h want 0000", k, sum); end
            vectors++; if (c_out !== 1'b0)   begin errors++; $display("FAIL reset_cout[%0d]: got %b want 0", k, c_out); end
            vectors++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf); end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_add;
        int   lat;
        exp_t e;
        issue(16'h1234, 16'h0FCD, 1'b0);
        wait_done(lat);
        vectors++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL add_scoreboard: got empty want 1 entry"); end
        else begin
            e = sb.pop_front();
            if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                errors++; $display("FAIL add_result: got %h/%b/%b want %h/%b/%b", sum, c_out, ovf, e.sum, e.c, e.v);
            end
            vectors++; if (e.sum !== 16'h2201) begin errors++; $display("FAIL add_model: got %h want 2201", e.sum); end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                vectors++;
                if (done !== 1'b0 || ready !== 1'b1 || sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                    errors++; $display("FAIL add_hold[%0d]: got d%b r%b %h/%b/%b want d0 r1 %h/%b/%b", i, done, ready, sum, c_out, ovf, e.sum, e.c, e.v);
                end
            end
        end
    endtask

    // Fixed boundary vectors: full carry chain, signed overflow, subtraction borrow and no-borrow cases.
    task automatic test_boundaries;
        logic [15:0] ta[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
        logic [15:0] tb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005};
        logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ws[4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
        logic        wc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        wv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          lat;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_done(lat);
            vectors++; if (lat !== 4) begin errors++; $display("FAIL bound_latency[%0d]: got %0d want 4", i, lat); end
            if (sb.size() != 0) e = sb.pop_front();
            vectors++;
            if (sum !== ws[i] || c_out !== wc[i] || ovf !== wv[i]) begin
                errors++; $display("FAIL bound_result[%0d]: got %h/%b/%b want %h/%b/%b", i, sum, c_out, ovf, ws[i], wc[i], wv[i]);
            end
            vectors++;
            if (e.sum !== ws[i] || e.c !== wc[i] || e.v !== wv[i]) begin
                errors++; $display("FAIL bound_model[%0d]: got %h/%b/%b want %h/%b/%b", i, e.sum, e.c, e.v, ws[i], wc[i], wv[i]);
            end
        end
    endtask

    task automatic test_random;
        int   lat;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(lat);
            vectors++;
            if (lat !== 4 || sb.size() == 0) begin
                errors++; $display("FAIL rand_done[%0d]: got latency %0d want 4", i, lat);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                    errors++; $display("FAIL rand_result[%0d]: got %h/%b/%b want %h/%b/%b", i, sum, c_out, ovf, e.sum, e.c, e.v);
                end
            end
        end
    endtask

    // Inputs change right after acceptance, and a start pulse mid-operation must be ignored.
    task automatic test_handshake;
        int   lat;
        int   extra;
        exp_t e;
        issue(16'hA5A5, 16'h5A5B, 1'b1);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
        @(negedge clk);
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_ready_run: got %b want 0", ready); end
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL hs_latency: got %0d want 3", lat); end
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL hs_scoreboard: got empty want 1 entry"); end
        else begin
            e = sb.pop_front();
            if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                errors++; $display("FAIL hs_result: got %h/%b/%b want %h/%b/%b", sum, c_out, ovf, e.sum, e.c, e.v);
            end
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin errors++; $display("FAIL hs_extra_done: got %0d want 0", extra); end
    endtask

    // Start held high; new operands are offered on every ready cycle. Expect one done every 5 cycles.
    task automatic test_back_to_back;
        int   issued = 0;
        int   got    = 0;
        int   prev   = -1;
        exp_t e;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (prev >= 0) begin
                    vectors++; if (cyc - prev !== 5) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", got, cyc - prev); end
                end
                prev = cyc;
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL b2b_scoreboard[%0d]: got empty want entry", got); end
                else begin
                    e = sb.pop_front();
                    if (sum !== e.sum || c_out !== e.c || ovf !== e.v) begin
                        errors++; $display("FAIL b2b_result[%0d]: got %h/%b/%b want %h/%b/%b", got, sum, c_out, ovf, e.sum, e.c, e.v);
                    end
                end
                got++;
            end
            if (ready === 1'b1) begin
                if (issued < 6) begin
                    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
                    sb.push_back(model(a, b, sub));
                    start = 1'b1;
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            end
        end
        start = 1'b0;
        vectors++; if (got !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got); end
        vectors++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int extra;
        issue(16'h8000, 16'h0001, 1'b1);
        wait_done(lat);
        sb.delete();
        issue(16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || sum !== 16'h0000 || c_out !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got r%b d%b %h/%b/%b want r1 d0 0000/0/0", ready, done, sum, c_out, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d want 0", extra); end
        vectors++;
        if (sum !== 16'h0000 || c_out !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrun_hold: got %h/%b/%b want 0000/0/0", sum, c_out, ovf);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_boundaries;
        test_random;
        test_handshake;
        test_back_to_back;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
